// File: rtl/rv_decode_stage.sv
// RV32I decode stage: sequences register-file reads, snoops writeback to keep
// operands coherent, and hands a decoded bundle to execute via valid/ready.
module rv_decode_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                flush,
  input  logic                if_valid,
  output logic                if_ready,
  input  logic [31:0]         if_instr,
  input  logic [XLEN-1:0]     if_pc,
  output logic [4:0]          rf_a1,
  output logic [4:0]          rf_a2,
  input  logic [XLEN-1:0]     rf_rd1,
  input  logic [XLEN-1:0]     rf_rd2,
  input  logic                wb_we,
  input  logic [4:0]          wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [XLEN-1:0]     ex_pc,
  output logic [XLEN-1:0]     ex_rs1_val,
  output logic [XLEN-1:0]     ex_rs2_val,
  output logic [XLEN-1:0]     ex_imm,
  output logic [4:0]          ex_rd,
  output logic [2:0]          ex_funct3,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_alu_src_imm,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_branch,
  output logic                ex_jump,
  output logic                ex_illegal
);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  state_t          state, state_nx;
  logic            accept;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic            fwd1_v, fwd2_v;
  logic [XLEN-1:0] fwd1_d, fwd2_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic [31:0]     imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] op1, op2, d_imm;
  alu_t            d_alu;
  logic            d_src_imm, d_rw, d_mr, d_mw, d_br, d_jp, d_ill;

  always_comb begin
    if_ready = !flush && (state == IDLE || (state == HOLD && ex_ready));
    accept   = if_valid && if_ready;
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = READ;
      READ:    state_nx = HOLD;
      HOLD:    if (ex_ready) state_nx = accept ? READ : IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  assign rf_a1 = (state == READ) ? instr_q[19:15] : if_instr[19:15];
  assign rf_a2 = (state == READ) ? instr_q[24:20] : if_instr[24:20];

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign rd     = instr_q[11:7];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];
  assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s  = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b  = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_u  = {instr_q[31:12], 12'b0};
  assign imm_j  = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

  // Operand priority: write on this edge, then write seen at accept, then RF read.
  always_comb begin
    op1 = rf_rd1;
    if (fwd1_v) op1 = fwd1_d;
    if (wb_we && wb_addr == rs1) op1 = wb_data;
    if (rs1 == 5'd0) op1 = '0;
    op2 = rf_rd2;
    if (fwd2_v) op2 = fwd2_d;
    if (wb_we && wb_addr == rs2) op2 = wb_data;
    if (rs2 == 5'd0) op2 = '0;
  end

  always_comb begin
    d_imm = '0; d_alu = ALU_ADD; d_src_imm = 1'b0; d_rw = 1'b0;
    d_mr = 1'b0; d_mw = 1'b0; d_br = 1'b0; d_jp = 1'b0; d_ill = 1'b0;
    unique case (opcode)
      OPC_LUI:    begin d_imm = imm_u; d_alu = ALU_PASSB; d_src_imm = 1'b1; d_rw = 1'b1; end
      OPC_AUIPC:  begin d_imm = imm_u; d_src_imm = 1'b1; d_rw = 1'b1; end
      OPC_JAL:    begin d_imm = imm_j; d_src_imm = 1'b1; d_rw = 1'b1; d_jp = 1'b1; end
      OPC_JALR:   begin d_imm = imm_i; d_src_imm = 1'b1; d_rw = 1'b1; d_jp = 1'b1; end
      OPC_BRANCH: begin d_imm = imm_b; d_alu = ALU_SUB; d_br = 1'b1; end
      OPC_LOAD:   begin d_imm = imm_i; d_src_imm = 1'b1; d_rw = 1'b1; d_mr = 1'b1; end
      OPC_STORE:  begin d_imm = imm_s; d_src_imm = 1'b1; d_mw = 1'b1; end
      OPC_OPIMM, OPC_OP: begin
        d_imm     = (opcode == OPC_OPIMM) ? imm_i : '0;
        d_src_imm = (opcode == OPC_OPIMM);
        d_rw      = 1'b1;
        unique case (funct3)
          3'b000:  d_alu = (opcode == OPC_OP && instr_q[30]) ? ALU_SUB : ALU_ADD;
          3'b001:  d_alu = ALU_SLL;
          3'b010:  d_alu = ALU_SLT;
          3'b011:  d_alu = ALU_SLTU;
          3'b100:  d_alu = ALU_XOR;
          3'b101:  d_alu = instr_q[30] ? ALU_SRA : ALU_SRL;
          3'b110:  d_alu = ALU_OR;
          default: d_alu = ALU_AND;
        endcase
      end
      default:    d_ill = 1'b1;
    endcase
    if (rd == 5'd0) d_rw = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= IDLE;
      instr_q        <= '0;
      pc_q           <= '0;
      fwd1_v         <= 1'b0;
      fwd2_v         <= 1'b0;
      fwd1_d         <= '0;
      fwd2_d         <= '0;
      ex_valid       <= 1'b0;
      ex_pc          <= '0;
      ex_rs1_val     <= '0;
      ex_rs2_val     <= '0;
      ex_imm         <= '0;
      ex_rd          <= '0;
      ex_funct3      <= '0;
      ex_alu_op      <= '0;
      ex_alu_src_imm <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_branch      <= 1'b0;
      ex_jump        <= 1'b0;
      ex_illegal     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        instr_q <= if_instr;
        pc_q    <= if_pc;
        fwd1_v  <= wb_we && wb_addr == if_instr[19:15];
        fwd2_v  <= wb_we && wb_addr == if_instr[24:20];
        fwd1_d  <= wb_data;
        fwd2_d  <= wb_data;
      end
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (state == READ) begin
        ex_valid       <= 1'b1;
        ex_pc          <= pc_q;
        ex_rs1_val     <= op1;
        ex_rs2_val     <= op2;
        ex_imm         <= d_imm;
        ex_rd          <= rd;
        ex_funct3      <= funct3;
        ex_alu_op      <= ALU_OP_W'(d_alu);
        ex_alu_src_imm <= d_src_imm;
        ex_reg_write   <= d_rw;
        ex_mem_read    <= d_mr;
        ex_mem_write   <= d_mw;
        ex_branch      <= d_br;
        ex_jump        <= d_jp;
        ex_illegal     <= d_ill;
      end else if (state == HOLD) begin
        if (ex_ready) ex_valid <= 1'b0;
        if (wb_we && wb_addr == rs1 && rs1 != 5'd0) ex_rs1_val <= wb_data;
        if (wb_we && wb_addr == rs2 && rs2 != 5'd0) ex_rs2_val <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed cases plus random traffic checked against
// an architectural register file and an ISA-level decode reference.
module tb_rv_decode_stage;
  logic        CLK = 1'b0;
  logic        RST, flush, if_valid, if_ready;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  rf_a1, rf_a2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;
  logic        ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_jump, ex_illegal;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  rv_decode_stage #(.XLEN(32), .ALU_OP_W(4)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_alu_op(ex_alu_op),
    .ex_alu_src_imm(ex_alu_src_imm), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_illegal(ex_illegal)
  );

  // Register file: synchronous read of the old contents, write on the same edge.
  logic [31:0] rf [32];
  always @(posedge CLK) begin
    rf_rd1 <= rf[rf_a1];
    rf_rd2 <= rf[rf_a2];
    if (wb_we && wb_addr != 5'd0) rf[wb_addr] <= wb_data;
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    int          acc_e;
  } item_t;
  item_t q[$];
  int    edges    = 0;
  bit    last_rst = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic bit head_vis();
    return q.size() > 0 && edges >= q[0].acc_e + 1;
  endfunction

  // ctl = {src_imm, reg_write, mem_read, mem_write, branch, jump, illegal}
  function automatic void ref_decode(input logic [31:0] i, output logic [31:0] imm,
                                     output logic [6:0] ctl, output logic [6:0] mask,
                                     output int alu, output bit has_imm, output bit has_alu);
    int          alu_tab [8];
    logic [31:0] sx, ii;
    alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    sx  = {32{i[31]}};
    ii  = 32'($signed(i) >>> 20);
    imm = '0; ctl = '0; mask = 7'h7F; alu = 0; has_imm = 1'b1; has_alu = 1'b0;
    case (i[6:0])
      7'h37, 7'h17: begin imm = i & 32'hFFFFF000; ctl = 7'b1100000; end
      7'h6F: begin
        imm  = (sx << 20) | (i & 32'h000FF000) | ((i >> 9) & 32'h800) | ((i >> 20) & 32'h7FE);
        ctl  = 7'b0100010; mask = 7'h3F;
      end
      7'h67: begin imm = ii; ctl = 7'b0100010; mask = 7'h3F; end
      7'h63: begin
        imm = (sx << 12) | ((i << 4) & 32'h800) | ((i >> 20) & 32'h7E0) | ((i >> 7) & 32'h1E);
        ctl = 7'b0000100;
      end
      7'h03: begin imm = ii; ctl = 7'b1110000; end
      7'h23: begin imm = (ii & ~32'h1F) | ((i >> 7) & 32'h1F); ctl = 7'b1001000; end
      7'h13, 7'h33: begin
        has_alu = 1'b1;
        alu     = alu_tab[i[14:12]];
        if (i[14:12] == 3'd5 && i[30]) alu = 7;
        if (i[6:0] == 7'h33) begin
          ctl = 7'b0100000; has_imm = 1'b0;
          if (i[14:12] == 3'd0 && i[30]) alu = 1;
        end else begin
          imm = ii; ctl = 7'b1100000;
        end
      end
      default: begin ctl = 7'b0000001; mask = 7'h3F; has_imm = 1'b0; end
    endcase
    if (i[11:7] == 5'd0) ctl[5] = 1'b0;
  endfunction

  task automatic check_regs();
    logic [31:0] e_imm, ins;
    logic [6:0]  e_ctl, m_ctl, o_ctl;
    logic [4:0]  r1, r2;
    int          e_alu;
    bit          h_imm, h_alu;
    o_ctl = {ex_alu_src_imm, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal};
    if (last_rst) begin
      chk("rst_ctl", {12'b0, ex_valid, ex_alu_op, ex_rd, ex_funct3, o_ctl}, 32'd0);
      chk("rst_pc_imm", ex_pc | ex_imm, 32'd0);
      chk("rst_ops", ex_rs1_val | ex_rs2_val, 32'd0);
    end else begin
      chk("ex_valid", 32'(ex_valid), 32'(head_vis()));
      if (head_vis()) begin
        ins = q[0].instr;
        r1  = ins[19:15];
        r2  = ins[24:20];
        chk("pc", ex_pc, q[0].pc);
        chk("rs1_val", ex_rs1_val, (r1 == 5'd0) ? 32'd0 : rf[r1]);
        chk("rs2_val", ex_rs2_val, (r2 == 5'd0) ? 32'd0 : rf[r2]);
        chk("rd_f3", {24'b0, ex_rd, ex_funct3}, {24'b0, ins[11:7], ins[14:12]});
        ref_decode(ins, e_imm, e_ctl, m_ctl, e_alu, h_imm, h_alu);
        chk("ctl", 32'(o_ctl & m_ctl), 32'(e_ctl & m_ctl));
        if (h_imm) chk("imm", ex_imm, e_imm);
        if (h_alu) chk("alu_op", 32'(ex_alu_op), 32'(e_alu));
      end
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, advance the model
  // across the posedge, then check registered outputs at the next negedge.
  task automatic cyc(input bit rst, input bit fl, input bit iv, input logic [31:0] ins,
                     input logic [31:0] pc, input bit er, input bit we,
                     input logic [4:0] wa, input logic [31:0] wd);
    bit          vis, rdy, acc, hs;
    logic [31:0] cur;
    RST = rst; flush = fl; if_valid = iv; if_instr = ins; if_pc = pc;
    ex_ready = er; wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    vis = head_vis();
    rdy = !fl && (q.size() == 0 || (vis && er));
    cur = (q.size() > 0 && !vis) ? q[0].instr : ins;
    if (!rst) begin
      chk("if_ready", 32'(if_ready), 32'(rdy));
      chk("rf_a", {22'b0, rf_a1, rf_a2}, {22'b0, cur[19:15], cur[24:20]});
    end
    acc = !rst && iv && rdy;
    hs  = !rst && !fl && vis && er;
    @(posedge CLK);
    edges++;
    if (rst || fl) q.delete();
    else begin
      if (hs) void'(q.pop_front());
      if (acc) q.push_back(item_t'{ins, pc, edges});
    end
    last_rst = rst;
    @(negedge CLK);
    check_regs();
  endtask

  task automatic idle(input bit er);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, er, 1'b0, 5'd0, 32'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [9];
    logic [31:0] w;
    int          k;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    w = $urandom;
    k = $urandom_range(0, 10);
    if (k < 9) w[6:0] = ops[k];
    else       w[6:0] = (k == 9) ? 7'h0B : 7'h7F;
    if ($urandom_range(0, 3) != 0) begin
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
    end
    if ($urandom_range(0, 4) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    RST = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    ex_ready = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    @(negedge CLK);

    // Preload the register file while the stage is held in reset.
    for (int r = 1; r < 32; r++)
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'(r), (r == 3) ? 32'h11 : $urandom);

    // addi x5,x0,7
    cyc(1'b0, 1'b0, 1'b1, 32'h00700293, 32'h100, 1'b1, 1'b0, 5'd0, 32'h0);
    chk("t1_valid_early", 32'(ex_valid), 32'd0);
    idle(1'b1);
    chk("t1_valid", 32'(ex_valid), 32'd1);
    chk("t1_imm", ex_imm, 32'd7);
    chk("t1_rd", 32'(ex_rd), 32'd5);
    chk("t1_rs1", ex_rs1_val, 32'd0);
    chk("t1_alu", 32'(ex_alu_op), 32'd0);
    chk("t1_ctl", 32'({ex_alu_src_imm, ex_reg_write}), 32'd3);

    // add x4,x3,x3 with x3 written on the accept edge
    cyc(1'b0, 1'b0, 1'b1, 32'h00318233, 32'h104, 1'b1, 1'b1, 5'd3, 32'h22);
    idle(1'b0);
    chk("t2_rs1", ex_rs1_val, 32'h22);
    chk("t2_rs2", ex_rs2_val, 32'h22);
    chk("t2_alu", 32'(ex_alu_op), 32'd0);

    // Stall with a write to x3 during HOLD
    for (int k = 0; k < 5; k++)
      cyc(1'b0, 1'b0, 1'b1, 32'h00700293, 32'h500, 1'b0, k == 1, 5'd3, 32'h33);
    chk("t3_rs1", ex_rs1_val, 32'h33);
    chk("t3_rs2", ex_rs2_val, 32'h33);
    chk("t3_rd", 32'(ex_rd), 32'd4);
    chk("t3_pc", ex_pc, 32'h104);
    chk("t3_if_ready", 32'(if_ready), 32'd0);

    // beq x1,x2,-4
    cyc(1'b0, 1'b0, 1'b1, 32'hFE208EE3, 32'h200, 1'b1, 1'b0, 5'd0, 32'h0);
    idle(1'b0);
    chk("t4_imm", ex_imm, 32'hFFFFFFFC);
    chk("t4_bits", 32'({ex_branch, ex_reg_write, ex_funct3}), 32'b10000);

    // unsupported opcode
    cyc(1'b0, 1'b0, 1'b1, 32'h0000007F, 32'h204, 1'b1, 1'b0, 5'd0, 32'h0);
    idle(1'b0);
    chk("t5_bits", 32'({ex_illegal, ex_reg_write, ex_mem_read, ex_mem_write}), 32'b1000);

    // flush in READ, then reset in HOLD
    idle(1'b1);
    cyc(1'b0, 1'b0, 1'b1, 32'h00700293, 32'h300, 1'b1, 1'b0, 5'd0, 32'h0);
    cyc(1'b0, 1'b1, 1'b1, 32'h00318233, 32'h304, 1'b1, 1'b0, 5'd0, 32'h0);
    chk("t6_flush_valid", 32'(ex_valid), 32'd0);
    idle(1'b1);
    chk("t6_flush_idle", 32'(ex_valid), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 32'h00318233, 32'h308, 1'b0, 1'b0, 5'd0, 32'h0);
    idle(1'b0);
    idle(1'b0);
    chk("t6_hold_valid", 32'(ex_valid), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    chk("t6_rst_valid", 32'(ex_valid), 32'd0);
    chk("t6_rst_rd", 32'(ex_rd), 32'd0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      cyc($urandom_range(0, 149) == 0, $urandom_range(0, 29) == 0,
          $urandom_range(0, 9) < 7, rand_instr(), $urandom & 32'hFFFFFFFC,
          $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
          ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3)), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
